mdu_iter: RTL

- Parametrised multi-cycle multiply/divide unit implementing the RV32M funct3 operation set.
- Sits beside the execute-stage ALU. Accepts one operation per start pulse and reports busy/done.
- The hazard unit treats busy as a stall source for fetch/decode/execute.
- Generalises the single-cycle XLEN-fixed ALU: operand width is a parameter, multiply/divide run iteratively with a start/busy/done handshake, and an in-flight op can be flushed.

---
 rtl/mdu_iter.sv | 239 +++++++++++++++++++++++
 1 files changed

// File: rtl/mdu_iter.sv
// mdu_iter: multi-cycle multiply/divide unit for the RV32M funct3 operation set.
//
// Multiplies by shift-add and divides by restoring radix-2, one bit per cycle,
// both on operand magnitudes; a final FIX cycle restores signs and picks the
// output half. Divide-by-zero and signed overflow skip the iteration.
//
// Optional feature: define MDU_FAST_MUL_EN to compute all multiplies with one
// combinational XLEN x XLEN multiplier at accept time (multiply latency 2).
//
// Ports:
//   clk        clock, rising edge
//   rst        asynchronous active-high reset
//   i_start    request, accepted only when not busy
//   i_op       000 MUL, 001 MULH, 010 MULHSU, 011 MULHU,
//              100 DIV, 101 DIVU, 110 REM, 111 REMU
//   i_src_a    rs1 operand (multiplicand / dividend)
//   i_src_b    rs2 operand (multiplier / divisor)
//   i_tag_in   destination tag captured with the operands
//   i_flush    abort the in-flight op
//   o_busy     op accepted and not yet completed
//   o_done     one-cycle pulse, o_result/o_tag_out valid
//   o_result   result, held until the next done
//   o_tag_out  tag of the completed op, held with o_result
module mdu_iter #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned TAG_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_start,
  input  logic [2:0]       i_op,
  input  logic [XLEN-1:0]  i_src_a,
  input  logic [XLEN-1:0]  i_src_b,
  input  logic [TAG_W-1:0] i_tag_in,
  input  logic             i_flush,
  output logic             o_busy,
  output logic             o_done,
  output logic [XLEN-1:0]  o_result,
  output logic [TAG_W-1:0] o_tag_out
);

  localparam int unsigned CNT_W = $clog2(XLEN);
  localparam logic [XLEN-1:0] MIN_VAL = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {StIdle, StRun, StFix, StDone} state_e;

  state_e r_state, w_state_nxt;

  logic [CNT_W-1:0]  r_cnt;
  logic [XLEN-1:0]   r_a;       // multiplicand magnitude
  logic [XLEN-1:0]   r_b;       // divisor magnitude
  logic [2*XLEN-1:0] r_acc;     // mul: {hi, lo} product; div: {remainder, quotient}
  logic              r_div;
  logic              r_sel;     // mul: take high half; div: take remainder
  logic              r_neg_q;   // negate product / quotient in FIX
  logic              r_neg_r;   // negate remainder in FIX
  logic [TAG_W-1:0]  r_tag;
  logic [XLEN-1:0]   r_result;
  logic [TAG_W-1:0]  r_tag_out;

  logic              w_accept;
  logic              w_last;
  logic              w_a_signed, w_b_signed, w_sa, w_sb;
  logic              w_div0, w_ovf, w_special, w_skip_run;
  logic [XLEN-1:0]   w_a_mag, w_b_mag;
  logic [2*XLEN-1:0] w_acc_init;
  logic [XLEN:0]     w_mul_sum;
  logic [2*XLEN-1:0] w_mul_next;
  logic [XLEN:0]     w_div_sh;
  logic              w_div_ge;
  logic [XLEN-1:0]   w_div_sub;
  logic [2*XLEN-1:0] w_div_next;
  logic [2*XLEN-1:0] w_p_fix;
  logic [XLEN-1:0]   w_q_fix, w_r_fix, w_fix_res;
`ifdef MDU_FAST_MUL_EN
  logic [2*XLEN-1:0] w_fast_prod;
`endif

  // ---------------------------------------------------------------------------
  // Accept-time operand conditioning
  // ---------------------------------------------------------------------------
  assign w_accept = i_start && !i_flush && (r_state == StIdle || r_state == StDone);

  always_comb begin
    w_a_signed = (i_op == 3'b001) || (i_op == 3'b010) || (i_op == 3'b100) || (i_op == 3'b110);
    w_b_signed = (i_op == 3'b001) || (i_op == 3'b100) || (i_op == 3'b110);
    w_sa       = w_a_signed && i_src_a[XLEN-1];
    w_sb       = w_b_signed && i_src_b[XLEN-1];
    w_a_mag    = w_sa ? -i_src_a : i_src_a;
    w_b_mag    = w_sb ? -i_src_b : i_src_b;
    w_div0     = i_op[2] && (i_src_b == '0);
    w_ovf      = i_op[2] && !i_op[0] && (i_src_a == MIN_VAL) && (i_src_b == {XLEN{1'b1}});
    w_special  = w_div0 || w_ovf;
  end

`ifdef MDU_FAST_MUL_EN
  assign w_fast_prod = {{XLEN{1'b0}}, w_a_mag} * {{XLEN{1'b0}}, w_b_mag};
`endif

  // Special cases load their final value so FIX only has to select it.
  always_comb begin
    w_skip_run = w_special;
    if (w_div0) begin
      w_acc_init = {i_src_a, {XLEN{1'b1}}};
    end else if (w_ovf) begin
      w_acc_init = {{XLEN{1'b0}}, MIN_VAL};
    end else if (i_op[2]) begin
      w_acc_init = {{XLEN{1'b0}}, w_a_mag};
    end else begin
      w_acc_init = {{XLEN{1'b0}}, w_b_mag};
    end
`ifdef MDU_FAST_MUL_EN
    if (!i_op[2]) begin
      w_skip_run = 1'b1;
      w_acc_init = w_fast_prod;
    end
`endif
  end

  // ---------------------------------------------------------------------------
  // Iteration step
  // ---------------------------------------------------------------------------
  always_comb begin
    // Shift-add: add multiplicand when the multiplier LSB is set, then shift right.
    w_mul_sum  = {1'b0, r_acc[2*XLEN-1:XLEN]} + (r_acc[0] ? {1'b0, r_a} : '0);
    w_mul_next = {w_mul_sum, r_acc[XLEN-1:1]};
    // Restoring divide: shift next dividend bit into the partial remainder.
    w_div_sh   = {r_acc[2*XLEN-1:XLEN], r_acc[XLEN-1]};
    w_div_ge   = (w_div_sh >= {1'b0, r_b});
    // Result of a successful subtract is below the divisor, so XLEN bits suffice.
    w_div_sub  = w_div_sh[XLEN-1:0] - r_b;
    w_div_next = w_div_ge ? {w_div_sub, r_acc[XLEN-2:0], 1'b1}
                          : {w_div_sh[XLEN-1:0], r_acc[XLEN-2:0], 1'b0};
  end

  assign w_last = (r_cnt == CNT_W'(XLEN - 1));

  // ---------------------------------------------------------------------------
  // Sign fix-up and output selection
  // ---------------------------------------------------------------------------
  always_comb begin
    w_p_fix   = r_neg_q ? -r_acc : r_acc;
    w_q_fix   = r_neg_q ? -r_acc[XLEN-1:0] : r_acc[XLEN-1:0];
    w_r_fix   = r_neg_r ? -r_acc[2*XLEN-1:XLEN] : r_acc[2*XLEN-1:XLEN];
    if (r_div) begin
      w_fix_res = r_sel ? w_r_fix : w_q_fix;
    end else begin
      w_fix_res = r_sel ? w_p_fix[2*XLEN-1:XLEN] : w_p_fix[XLEN-1:0];
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: state register / next state / outputs
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      StIdle, StDone: begin
        if (w_accept) begin
          w_state_nxt = w_skip_run ? StFix : StRun;
        end else begin
          w_state_nxt = StIdle;
        end
      end
      StRun: begin
        if (i_flush) begin
          w_state_nxt = StIdle;
        end else if (w_last) begin
          w_state_nxt = StFix;
        end
      end
      StFix: begin
        w_state_nxt = i_flush ? StIdle : StDone;
      end
      default: w_state_nxt = StIdle;
    endcase
  end

  always_comb begin
    o_busy = 1'b0;
    o_done = 1'b0;
    unique case (r_state)
      StRun, StFix: o_busy = 1'b1;
      StDone:       o_done = 1'b1;
      default:      ;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt     <= '0;
      r_a       <= '0;
      r_b       <= '0;
      r_acc     <= '0;
      r_div     <= 1'b0;
      r_sel     <= 1'b0;
      r_neg_q   <= 1'b0;
      r_neg_r   <= 1'b0;
      r_tag     <= '0;
      r_result  <= '0;
      r_tag_out <= '0;
    end else begin
      if (w_accept) begin
        r_cnt   <= '0;
        r_a     <= w_a_mag;
        r_b     <= w_b_mag;
        r_acc   <= w_acc_init;
        r_div   <= i_op[2];
        r_sel   <= i_op[2] ? i_op[1] : (i_op[1:0] != 2'b00);
        r_neg_q <= (w_sa ^ w_sb) && !w_special;
        r_neg_r <= w_sa && !w_special;
        r_tag   <= i_tag_in;
      end else if (r_state == StRun) begin
        r_cnt <= r_cnt + 1'b1;
        r_acc <= r_div ? w_div_next : w_mul_next;
      end
      // Result commits only when FIX completes unflushed.
      if (r_state == StFix && !i_flush) begin
        r_result  <= w_fix_res;
        r_tag_out <= r_tag;
      end
    end
  end

  assign o_result  = r_result;
  assign o_tag_out = r_tag_out;

endmodule
